// File: rtl/npu_conv_read_seq.sv
`default_nettype none
// ============================================================================
//  Module   : npu_conv_read_seq
//  Purpose  : Read sequencer for npu_simple running a 3x3 conv followed by a
//             2x2 maxpool. Walks the feature map in column tiles, row pairs,
//             column pairs and 2x2 pool quadrants, and issues one pixel per
//             cycle as nine tap addresses plus zero-padding tap enables. Each
//             issued pixel is tagged with its pooled output coordinate.
//  Ports    :
//    clk          clock
//    reset        asynchronous active-low reset
//    start        one-cycle start pulse, accepted only while idle
//    cfg_width    feature-map width  (even, >=2), sampled at start
//    cfg_height   feature-map height (even, >=2), sampled at start
//    cfg_pad      1 = mask taps falling outside the map, sampled at start
//    stall        1 = hold the current pixel (input memory not ready)
//    readi_w      tap columns {t0..t8}, t0 = (-1,-1), t4 = centre
//    readi_h      tap rows, same tap order as readi_w
//    en_read      tap enables, bit 8 = t0 ... bit 0 = t8
//    en_bias      1 while a pixel is issued
//    en_pe        1 = outputs carry a valid pixel issue
//    pool_x       pooled output column of the issued pixel
//    pool_y       pooled output row of the issued pixel
//    pool_last    1 on the last pixel of a 2x2 pool group
//    busy         1 while running or draining
//    done         one-cycle pulse at the end of the drain
//  Revision : 1.0 - initial release
// ============================================================================
module npu_conv_read_seq #(
    parameter int WIDTH_B  = 7,
    parameter int HEIGHT_B = 3,
    parameter int TILE_W   = 68,
    parameter int HALO_COL = 68,
    parameter int PIPE_LAT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            cfg_width,
    input  logic [7:0]            cfg_height,
    input  logic                  cfg_pad,
    input  logic                  stall,
    output logic [WIDTH_B*9-1:0]  readi_w,
    output logic [HEIGHT_B*9-1:0] readi_h,
    output logic [8:0]            en_read,
    output logic                  en_bias,
    output logic                  en_pe,
    output logic [6:0]            pool_x,
    output logic [6:0]            pool_y,
    output logic                  pool_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int               c_CNT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(PIPE_LAT - 1);
    localparam logic [8:0]       c_TILE_W   = 9'(TILE_W);

    // ------------------------------------------------------------------
    // State and loop counters. The loop counters always point at the
    // next pixel to be issued; they rest at zero while idle.
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [7:0]         r_width;
    logic [7:0]         r_height;
    logic               r_pad;
    logic [8:0]         r_base;       // global column of the current tile start
    logic [7:0]         r_j;          // row pair
    logic [7:0]         r_k;          // tile-local column pair
    logic [1:0]         r_l;          // pool quadrant
    logic               r_all_issued; // last pixel is on the outputs
    logic [c_CNT_W-1:0] r_drain_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH_B*9-1:0]  r_readi_w;
    logic [HEIGHT_B*9-1:0] r_readi_h;
    logic [8:0]            r_en_read;
    logic                  r_en_bias;
    logic                  r_en_pe;
    logic [6:0]            r_pool_x;
    logic [6:0]            r_pool_y;
    logic                  r_pool_last;
    logic                  r_busy;
    logic                  r_done;

    // While idle the configuration registers are stale, so the first pixel
    // (issued on the start edge) is computed straight from the cfg inputs.
    logic [7:0] w_width;
    logic [7:0] w_height;
    logic       w_pad;

    assign w_width  = (r_state == S_IDLE) ? cfg_width  : r_width;
    assign w_height = (r_state == S_IDLE) ? cfg_height : r_height;
    assign w_pad    = (r_state == S_IDLE) ? cfg_pad    : r_pad;

    // ------------------------------------------------------------------
    // Geometry of the pixel addressed by the loop counters.
    // Quadrant order (0,0),(0,1),(1,1),(1,0): w = l[1], h = l[1]^l[0].
    // ------------------------------------------------------------------
    logic       w_qw;
    logic       w_qh;
    logic [7:0] w_c;   // tile-local centre column
    logic [7:0] w_r;   // centre row
    logic [8:0] w_g;   // global centre column

    assign w_qw = r_l[1];
    assign w_qh = r_l[1] ^ r_l[0];
    assign w_c  = r_k + {7'd0, w_qw};
    assign w_r  = r_j + {7'd0, w_qh};
    assign w_g  = r_base + {1'b0, w_c};

    // ------------------------------------------------------------------
    // Loop bounds. All comparisons are "more to go" tests so that odd or
    // tiny configurations still run out and reach the drain.
    // ------------------------------------------------------------------
    logic [8:0] w_rem;
    logic [8:0] w_tile_cols;
    logic [9:0] w_base_step;
    logic       w_quad_end;
    logic       w_k_more;
    logic       w_j_more;
    logic       w_i_more;
    logic       w_last;
    logic       w_issue;

    assign w_rem       = ({1'b0, w_width} > r_base) ? ({1'b0, w_width} - r_base) : 9'd0;
    assign w_tile_cols = (w_rem > c_TILE_W) ? c_TILE_W : w_rem;
    assign w_base_step = {1'b0, r_base} + {1'b0, c_TILE_W};
    assign w_quad_end  = (r_l == 2'd3);
    assign w_k_more    = (({1'b0, r_k} + 9'd2) < w_tile_cols);
    assign w_j_more    = (({1'b0, r_j} + 9'd2) < {1'b0, w_height});
    assign w_i_more    = (w_base_step < {2'b00, w_width});
    assign w_last      = w_quad_end && !w_k_more && !w_j_more && !w_i_more;

    assign w_issue = ((r_state == S_IDLE) && start) ||
                     ((r_state == S_RUN) && !r_all_issued && !stall);

    // ------------------------------------------------------------------
    // Tap address and mask generation, tap t = (dy+1)*3 + (dx+1).
    // ------------------------------------------------------------------
    logic [WIDTH_B*9-1:0]  w_pix_w;
    logic [HEIGHT_B*9-1:0] w_pix_h;
    logic [8:0]            w_pix_en;

    for (genvar t = 0; t < 9; t++) begin : g_tap
        localparam int c_DX = (t % 3) - 1;
        localparam int c_DY = (t / 3) - 1;

        logic signed [10:0]  w_gx;
        logic signed [10:0]  w_ry;
        logic                w_inside;
        logic                w_en;
        logic                w_halo;
        logic [WIDTH_B-1:0]  w_col;
        logic [HEIGHT_B-1:0] w_row;

        assign w_gx     = $signed({2'b00, w_g}) + 11'(c_DX);
        assign w_ry     = $signed({3'b000, w_r}) + 11'(c_DY);
        assign w_inside = (w_gx >= 11'sd0) && (w_gx < $signed({3'b000, w_width})) &&
                          (w_ry >= 11'sd0) && (w_ry < $signed({3'b000, w_height}));
        assign w_en     = !w_pad || w_inside;

        // Left neighbour of a tile's first column lives in the halo column
        // of the input memory for every tile but the first.
        assign w_halo = (c_DX == -1) && (w_c == 8'd0) && (r_base != 9'd0);
        assign w_col  = w_halo ? WIDTH_B'(HALO_COL) : WIDTH_B'(w_c + 8'(c_DX));
        // Input memory rows are a circular buffer.
        assign w_row  = HEIGHT_B'(w_r + 8'(c_DY));

        assign w_pix_w[(8-t)*WIDTH_B +: WIDTH_B]   = w_en ? w_col : '0;
        assign w_pix_h[(8-t)*HEIGHT_B +: HEIGHT_B] = w_en ? w_row : '0;
        assign w_pix_en[8-t]                       = w_en;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_all_issued) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loop counters, configuration capture and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_width      <= '0;
            r_height     <= '0;
            r_pad        <= 1'b0;
            r_base       <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_l          <= '0;
            r_all_issued <= 1'b0;
            r_drain_cnt  <= '0;
            r_readi_w    <= '0;
            r_readi_h    <= '0;
            r_en_read    <= '0;
            r_en_bias    <= 1'b0;
            r_en_pe      <= 1'b0;
            r_pool_x     <= '0;
            r_pool_y     <= '0;
            r_pool_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_width  <= cfg_width;
                r_height <= cfg_height;
                r_pad    <= cfg_pad;
            end

            if (w_issue) begin
                r_readi_w    <= w_pix_w;
                r_readi_h    <= w_pix_h;
                r_en_read    <= w_pix_en;
                r_en_bias    <= 1'b1;
                r_en_pe      <= 1'b1;
                r_pool_x     <= w_g[7:1];
                r_pool_y     <= w_r[7:1];
                r_pool_last  <= w_quad_end;
                r_all_issued <= w_last;
                // Nested loop advance: l innermost, then k, j, tile.
                // After the last pixel every counter wraps back to zero.
                if (!w_quad_end) begin
                    r_l <= r_l + 2'd1;
                end else begin
                    r_l <= 2'd0;
                    if (w_k_more) begin
                        r_k <= r_k + 8'd2;
                    end else begin
                        r_k <= 8'd0;
                        if (w_j_more) begin
                            r_j <= r_j + 8'd2;
                        end else begin
                            r_j <= 8'd0;
                            r_base <= w_i_more ? (r_base + c_TILE_W) : 9'd0;
                        end
                    end
                end
            end else begin
                // Stalled or not running: addresses and tags hold.
                r_en_bias    <= 1'b0;
                r_en_pe      <= 1'b0;
                r_all_issued <= 1'b0;
            end

            r_drain_cnt <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DRAIN) && (w_cnt_nxt == c_LAST_CNT);
        end
    end

    assign readi_w   = r_readi_w;
    assign readi_h   = r_readi_h;
    assign en_read   = r_en_read;
    assign en_bias   = r_en_bias;
    assign en_pe     = r_en_pe;
    assign pool_x    = r_pool_x;
    assign pool_y    = r_pool_y;
    assign pool_last = r_pool_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_npu_conv_read_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_conv_read_seq
//  Purpose  : Self-checking bench for npu_conv_read_seq. A reference model
//             fills a scoreboard with the expected pixel stream at start;
//             observed en_pe pixels are popped and compared in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_conv_read_seq;

    localparam int c_TILE = 68;
    localparam int c_HALO = 68;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic        cfg_pad;
    logic        stall;
    logic [62:0] readi_w;
    logic [26:0] readi_h;
    logic [8:0]  en_read;
    logic        en_bias;
    logic        en_pe;
    logic [6:0]  pool_x;
    logic [6:0]  pool_y;
    logic        pool_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [62:0] w;
        logic [26:0] h;
        logic [8:0]  en;
        logic [6:0]  px;
        logic [6:0]  py;
        logic        last;
    } pix_t;

    pix_t exp_q[$];
    pix_t obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    npu_conv_read_seq #(
        .WIDTH_B (7),
        .HEIGHT_B(3),
        .TILE_W  (c_TILE),
        .HALO_COL(c_HALO),
        .PIPE_LAT(7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_width (cfg_width),
        .cfg_height(cfg_height),
        .cfg_pad   (cfg_pad),
        .stall     (stall),
        .readi_w   (readi_w),
        .readi_h   (readi_h),
        .en_read   (en_read),
        .en_bias   (en_bias),
        .en_pe     (en_pe),
        .pool_x    (pool_x),
        .pool_y    (pool_y),
        .pool_last (pool_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one issued pixel.
    function automatic pix_t model_pix(input int base, input int c, input int r,
                                       input int W, input int H, input bit pad);
        pix_t p;
        int dx, dy, gx, ry, col, row;
        bit en;
        p = '0;
        for (int t = 0; t < 9; t++) begin
            dx  = (t % 3) - 1;
            dy  = (t / 3) - 1;
            gx  = base + c + dx;
            ry  = r + dy;
            en  = !pad || (gx >= 0 && gx < W && ry >= 0 && ry < H);
            col = ((c + dx) < 0 && base > 0) ? c_HALO : ((c + dx) & 127);
            row = ry & 7;
            if (en) begin
                p.w[(8-t)*7 +: 7] = col[6:0];
                p.h[(8-t)*3 +: 3] = row[2:0];
                p.en[8-t]         = 1'b1;
            end
        end
        p.px = 7'((base + c) >> 1);
        p.py = 7'(r >> 1);
        return p;
    endfunction

    task automatic push_expected(input int W, input int H, input bit pad);
        pix_t p;
        int   tw;
        for (int base = 0; base < W; base += c_TILE) begin
            tw = ((W - base) < c_TILE) ? (W - base) : c_TILE;
            for (int j = 0; j < H; j += 2)
                for (int k = 0; k < tw; k += 2)
                    for (int l = 0; l < 4; l++) begin
                        p = model_pix(base, k + ((l >= 2) ? 1 : 0),
                                      j + ((l == 1 || l == 2) ? 1 : 0), W, H, pad);
                        p.last = (l == 3);
                        exp_q.push_back(p);
                    end
        end
    endtask

    // Drives one operation and records the observed pixel stream.
    // stall_at / start_at: pixel count after which a stall burst or a stray
    // start pulse is applied (-1 = none).
    task automatic run_op(input int W, input int H, input bit pad,
                          input int stall_at, input int stall_len, input int start_at,
                          output int n_pix, output int gap, output int frozen_bad,
                          output int first_cyc, output bit timeout, output bit tail_bad);
        pix_t cur, prev;
        int   last_cyc, stall_left;
        bit   prev_stall, stall_started;
        n_pix = 0; gap = -1; frozen_bad = 0; first_cyc = -1; timeout = 1'b1;
        tail_bad = 1'b0; last_cyc = 0; stall_left = 0; prev_stall = 1'b0;
        stall_started = 1'b0; prev = '0;
        obs_q.delete();
        @(negedge clk);
        cfg_width = 8'(W); cfg_height = 8'(H); cfg_pad = pad; start = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            cur = {readi_w, readi_h, en_read, pool_x, pool_y, pool_last};
            if (prev_stall && (en_pe || en_bias || cur !== prev)) frozen_bad++;
            if (en_pe) begin
                obs_q.push_back(cur);
                n_pix++;
                last_cyc = cyc;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (done) begin
                gap = cyc - last_cyc;
                timeout = 1'b0;
                break;
            end
            prev = cur;
            start = 1'b0;
            if (start_at >= 0 && en_pe && n_pix == start_at) begin
                start = 1'b1; cfg_width = 8'd2; cfg_height = 8'd2;
            end
            if (stall_left > 0) begin
                stall = 1'b1; stall_left--;
            end else if (stall_at >= 0 && en_pe && n_pix == stall_at && !stall_started) begin
                stall = 1'b1; stall_left = stall_len - 1; stall_started = 1'b1;
            end else begin
                stall = 1'b0;
            end
            prev_stall = stall;
        end
        start = 1'b0;
        stall = 1'b0;
        if (!timeout) begin
            @(negedge clk);
            tail_bad = done || busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_pad = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({readi_w, readi_h, en_read, en_bias, en_pe, pool_x, pool_y, pool_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got w=%h h=%h en=%b busy=%b required all zero",
                     readi_w, readi_h, en_read, busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || en_pe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b en_pe=%b required 0 0", busy, en_pe);
        end
    endtask

    task automatic test_basic();
        int n_pix, gap, frz, first, idx; bit to, tail; pix_t e, o;
        exp_q.delete(); push_expected(4, 4, 1'b1);
        run_op(4, 4, 1'b1, -1, 0, -1, n_pix, gap, frz, first, to, tail);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout got no done required done"); end
        n_tests++; if (n_pix != 16) begin n_fail++; $display("FAIL basic_count got %0d required 16", n_pix); end
        n_tests++; if (gap != 7) begin n_fail++; $display("FAIL basic_done_gap got %0d required 7", gap); end
        n_tests++; if (first != 0) begin n_fail++; $display("FAIL basic_first_latency got %0d required 0", first); end
        n_tests++; if (tail) begin n_fail++; $display("FAIL basic_tail got done|busy=1 required 0"); end
        n_tests++;
        if (obs_q.size() < 2 || obs_q[0].en !== 9'b000011011) begin
            n_fail++; $display("FAIL basic_pix1_mask got %b required 000011011", obs_q[0].en);
        end
        n_tests++;
        if (obs_q.size() < 2 || {obs_q[0].w[28 +: 7], obs_q[0].h[12 +: 3]} !== 10'd0) begin
            n_fail++; $display("FAIL basic_pix1_centre got col=%0d row=%0d required 0 0",
                               obs_q[0].w[28 +: 7], obs_q[0].h[12 +: 3]);
        end
        n_tests++;
        if (obs_q.size() < 2 || obs_q[1].en !== 9'b011011011) begin
            n_fail++; $display("FAIL basic_pix2_mask got %b required 011011011", obs_q[1].en);
        end
        n_tests++;
        if (obs_q.size() < 16 || obs_q[13].en !== 9'b111111000 || obs_q[14].en !== 9'b110110000) begin
            n_fail++; $display("FAIL basic_bottom_masks got %b %b required 111111000 110110000",
                               obs_q[13].en, obs_q[14].en);
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL basic_pix%0d got %h required %h", idx, o, e); end
            idx++;
        end
        n_tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL basic_leftover got exp=%0d obs=%0d required 0 0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_two_tiles(input int W, input int H);
        int n_pix, gap, frz, first, idx; bit to, tail; pix_t e, o;
        exp_q.delete(); push_expected(W, H, 1'b1);
        run_op(W, H, 1'b1, -1, 0, -1, n_pix, gap, frz, first, to, tail);
        n_tests++; if (to) begin n_fail++; $display("FAIL tiles%0d_timeout got no done required done", W); end
        n_tests++; if (n_pix != W*H) begin n_fail++; $display("FAIL tiles%0d_count got %0d required %0d", W, n_pix, W*H); end
        if (W == 136) begin
            // Tile 1, c=0, r=1: left taps read the halo column, no masking.
            n_tests++;
            if (obs_q.size() < 274 || obs_q[273].w[56 +: 7] !== 7'd68 || obs_q[273].w[35 +: 7] !== 7'd68 ||
                obs_q[273].w[14 +: 7] !== 7'd68 || obs_q[273].px !== 7'd34 || obs_q[273].en !== 9'h1FF) begin
                n_fail++;
                $display("FAIL tiles_halo got t0=%0d t3=%0d t6=%0d px=%0d en=%b required 68 68 68 34 111111111",
                         obs_q[273].w[56 +: 7], obs_q[273].w[35 +: 7], obs_q[273].w[14 +: 7],
                         obs_q[273].px, obs_q[273].en);
            end
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL tiles%0d_pix%0d got %h required %h", W, idx, o, e); end
            idx++;
        end
        n_tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL tiles%0d_leftover got exp=%0d obs=%0d required 0 0", W, exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_no_pad();
        int n_pix, gap, frz, first, idx; bit to, tail; pix_t e, o;
        exp_q.delete(); push_expected(4, 4, 1'b0);
        run_op(4, 4, 1'b0, -1, 0, -1, n_pix, gap, frz, first, to, tail);
        n_tests++; if (n_pix != 16 || to) begin n_fail++; $display("FAIL nopad_count got %0d to=%b required 16 0", n_pix, to); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL nopad_pix%0d got %h required %h", idx, o, e); end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        int n_pix, gap, frz, first, idx; bit to, tail; pix_t e, o;
        exp_q.delete(); push_expected(4, 4, 1'b1);
        run_op(4, 4, 1'b1, 6, 3, -1, n_pix, gap, frz, first, to, tail);
        n_tests++; if (to) begin n_fail++; $display("FAIL stall_timeout got no done required done"); end
        n_tests++; if (n_pix != 16) begin n_fail++; $display("FAIL stall_count got %0d required 16", n_pix); end
        n_tests++; if (frz != 0) begin n_fail++; $display("FAIL stall_frozen got %0d bad cycles required 0", frz); end
        n_tests++; if (gap != 7) begin n_fail++; $display("FAIL stall_done_gap got %0d required 7", gap); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL stall_pix%0d got %h required %h", idx, o, e); end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_start_while_busy();
        int n_pix, gap, frz, first, idx; bit to, tail; pix_t e, o;
        exp_q.delete(); push_expected(4, 4, 1'b1);
        run_op(4, 4, 1'b1, -1, 0, 5, n_pix, gap, frz, first, to, tail);
        n_tests++; if (n_pix != 16 || to) begin n_fail++; $display("FAIL busystart_count got %0d to=%b required 16 0", n_pix, to); end
        n_tests++; if (tail) begin n_fail++; $display("FAIL busystart_tail got done|busy=1 required 0"); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL busystart_pix%0d got %h required %h", idx, o, e); end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int cnt, bad, n_pix, gap, frz, first, idx; bit hit, to, tail; pix_t e, o;
        exp_q.delete();
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_pad = 1'b1; start = 1'b1;
        cnt = 0; hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (en_pe) cnt++;
            if (cnt == 5) begin hit = 1'b1; break; end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach got %0d pixels required 5", cnt); end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({readi_w, readi_h, en_read, en_bias, en_pe, pool_x, pool_y, pool_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async got w=%h h=%h en=%b en_pe=%b busy=%b required all zero",
                     readi_w, readi_h, en_read, en_pe, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy || en_pe) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d active cycles required 0", bad); end
        push_expected(2, 2, 1'b1);
        run_op(2, 2, 1'b1, -1, 0, -1, n_pix, gap, frz, first, to, tail);
        n_tests++; if (n_pix != 4 || to) begin n_fail++; $display("FAIL rstmid_restart_count got %0d to=%b required 4 0", n_pix, to); end
        n_tests++; if (gap != 7) begin n_fail++; $display("FAIL rstmid_restart_gap got %0d required 7", gap); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rstmid_pix%0d got %h required %h", idx, o, e); end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_tiles(136, 4);
        test_two_tiles(70, 2);
        test_no_pad();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
